// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings, receiver FSM states and the
// default oversample ratio used by RX, TX and the baud tick generator.
package uart_pkg;

  localparam int OVERSAMPLE_DFLT = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // The reserved encoding behaves as "no parity bit on the wire".
  function automatic logic par_enabled(input par_mode_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver boundary: line, tick and parity-mode inputs plus the result word.
// slave = receiver side, master = the pad/tick driver and command parser side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_sample_tick;
  logic                 i_rx;
  logic [1:0]           i_parity_mode;
  logic                 o_rx_done_tick;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_break_tick;

  modport slave (
    input  i_sample_tick, i_rx, i_parity_mode,
    output o_rx_done_tick, o_rx_data, o_parity_err, o_frame_err, o_break_tick
  );

  modport master (
    output i_sample_tick, i_rx, i_parity_mode,
    input  o_rx_done_tick, o_rx_data, o_parity_err, o_frame_err, o_break_tick
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop line synchroniser; with UART_RX_MAJORITY_EN, rx_bit is the 2-of-3 vote
// of rx_s over the current and two previous sample ticks, otherwise rx_bit = rx_s.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic rx,
  output logic rx_s,
  output logic rx_bit
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (sample_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  // At a decision tick hist holds the two preceding tick samples.
  assign rx_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  logic unused_tick;
  assign unused_tick = sample_tick;
  assign rx_bit      = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: false-start rejection, runtime parity, stop/break checks.
// Optional UART_RX_MAJORITY_EN moves every bit decision to a 3-sample vote one tick later.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DFLT,
  parameter int STOP_BITS  = 1
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_cfg_if.slave rx_if
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TICK_W-1:0] START_PT = TICK_W'(OVERSAMPLE / 2);
`else
  localparam logic [TICK_W-1:0] START_PT = TICK_W'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic rx_s, rx_bit, tick;

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     nbit_q, nbit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  par_mode_e            pmode_q, pmode_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 done_q, done_d, brk_q, brk_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 perr_o_q, perr_o_d, ferr_o_q, ferr_o_d;
  logic                 par_exp, ferr_final;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (rx_if.i_sample_tick),
    .rx          (rx_if.i_rx),
    .rx_s        (rx_s),
    .rx_bit      (rx_bit)
  );

  assign tick       = rx_if.i_sample_tick;
  assign par_exp    = (pmode_q == PAR_ODD) ? ~^shreg_q : ^shreg_q;
  assign ferr_final = ferr_q | ~rx_bit;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    nbit_d   = nbit_q;
    shreg_d  = shreg_q;
    pmode_d  = pmode_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    done_d   = 1'b0;
    brk_d    = 1'b0;
    rdata_d  = rdata_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          pmode_d = par_mode_e'(rx_if.i_parity_mode);
          tick_d  = '0;
          nbit_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_q == START_PT) begin
            tick_d  = '0;
            state_d = rx_bit ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shreg_d = {rx_bit, shreg_q[DATA_BITS-1:1]};
            if (nbit_q == DATA_LAST) begin
              nbit_d  = '0;
              state_d = par_enabled(pmode_q) ? S_PARITY : S_STOP;
            end else begin
              nbit_d = nbit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            perr_d  = (rx_bit != par_exp);
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            ferr_d = ferr_final;
            // Leave at the last stop sample so the next falling edge can resync.
            if (nbit_q == STOP_LAST) begin
              state_d  = S_IDLE;
              done_d   = 1'b1;
              rdata_d  = shreg_q;
              perr_o_d = perr_q;
              ferr_o_d = ferr_final;
              brk_d    = ferr_final && (shreg_q == '0);
            end else begin
              nbit_d = nbit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      nbit_q   <= '0;
      shreg_q  <= '0;
      pmode_q  <= PAR_NONE;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
      brk_q    <= 1'b0;
      rdata_q  <= '0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      nbit_q   <= nbit_d;
      shreg_q  <= shreg_d;
      pmode_q  <= pmode_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      done_q   <= done_d;
      brk_q    <= brk_d;
      rdata_q  <= rdata_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
    end
  end

  assign rx_if.o_rx_done_tick = done_q;
  assign rx_if.o_rx_data      = rdata_q;
  assign rx_if.o_parity_err   = perr_o_q;
  assign rx_if.o_frame_err    = ferr_o_q;
  assign rx_if.o_break_tick   = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are built from plain bit lists, the expected
// result word and latency are queued at send time and checked when done pulses.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int DB      = 8;
  localparam int OS      = 16;
  localparam int SB      = 2;
  localparam int TPER    = 3;
  localparam int BIT_CLK = OS * TPER;
`ifdef UART_RX_MAJORITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         t0;
    int         nt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  uart_rx_cfg_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"},  32'(rx_if.o_rx_done_tick), 0);
    check({tag, "_data"},  32'(rx_if.o_rx_data), 0);
    check({tag, "_perr"},  32'(rx_if.o_parity_err), 0);
    check({tag, "_ferr"},  32'(rx_if.o_frame_err), 0);
    check({tag, "_break"}, 32'(rx_if.o_break_tick), 0);
  endtask

  task automatic idle(input int n);
    rx_if.i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // abort_at >= 0 stops driving before that bit index and queues no expectation.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input bit flip,
                            input bit s1_low, input int abort_at);
    logic bits[$];
    exp_t e;
    bit   pen;
    logic pbit;
    pen  = (pm == PAR_EVEN) || (pm == PAR_ODD);
    pbit = ($countones(d) % 2 == 1);
    if (pm == PAR_ODD) pbit = ~pbit;
    if (flip) pbit = ~pbit;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(~s1_low);
    bits.push_back(1'b1);
    @(negedge clk);
    rx_if.i_parity_mode = pm;
    e.data = d;
    e.perr = pen && flip;
    e.ferr = s1_low;
    e.brk  = s1_low && (d == 8'h00);
    e.t0   = cyc;
    e.nt   = (1 + DB + int'(pen) + SB) * OS - OS / 2 + EXTRA;
    if (abort_at < 0) q.push_back(e);
    for (int b = 0; b < bits.size(); b++) begin
      if (b == abort_at) return;
      rx_if.i_rx = bits[b];
      repeat (BIT_CLK) @(negedge clk);
      // Mode changes after start detect must not affect this frame.
      if (b == 0) rx_if.i_parity_mode = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int tc = 0;
    rx_if.i_sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      rx_if.i_sample_tick = (tc == 0);
      tc = (tc + 1) % TPER;
    end
  end

  initial begin
    exp_t e;
    int   lat, lo, hi;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_if.o_break_tick) check("break_with_done", 32'(rx_if.o_rx_done_tick), 1);
      if (rx_if.o_rx_done_tick) begin
        check("done_single_clk", 32'(prev_done), 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual data=%0h required no done", rx_if.o_rx_data);
        end else begin
          e = q.pop_front();
          check("data",  32'(rx_if.o_rx_data), 32'(e.data));
          check("perr",  32'(rx_if.o_parity_err), 32'(e.perr));
          check("ferr",  32'(rx_if.o_frame_err), 32'(e.ferr));
          check("break", 32'(rx_if.o_break_tick), 32'(e.brk));
          lat = cyc - e.t0;
          lo  = e.nt * TPER + 1;
          hi  = e.nt * TPER + TPER;
          check("latency", 32'(lat), 32'((lat < lo) ? lo : ((lat > hi) ? hi : lat)));
        end
      end
      prev_done = rx_if.o_rx_done_tick;
    end
  end

  initial begin
    int wait_cyc;
    rx_if.i_rx = 1'b1;
    rx_if.i_parity_mode = 2'b00;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(20);

    send_frame(8'h55, PAR_NONE, 1'b0, 1'b0, -1); idle(30);
    send_frame(8'hA5, PAR_EVEN, 1'b1, 1'b0, -1); idle(30);
    send_frame(8'h3C, PAR_NONE, 1'b0, 1'b1, -1); idle(30);
    send_frame(8'h00, PAR_NONE, 1'b0, 1'b1, -1); idle(30);

    // 4-tick low glitch must be rejected as a false start.
    rx_if.i_rx = 1'b0;
    repeat (4 * TPER) @(negedge clk);
    idle(100);
    send_frame(8'h81, PAR_NONE, 1'b0, 1'b0, -1); idle(30);

    // Reset after data bit 3 drops the frame and clears the held result.
    send_frame(8'h5A, PAR_NONE, 1'b0, 1'b0, 5);
    rst_n = 1'b0;
    rx_if.i_rx = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    idle(30);
    send_frame(8'h12, PAR_NONE, 1'b0, 1'b0, -1); idle(30);

    send_frame(8'hFF, PAR_ODD, 1'b0, 1'b0, -1);
    send_frame(8'h00, PAR_ODD, 1'b0, 1'b0, -1);
    idle(30);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      send_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0), -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 100)));
    end
    idle(30);

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 5000) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
